// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: debounces PLL lock, sequences downstream reset/ready, counts lock losses, emits aligned clock enables.
// Optional lock timeout enabled by defining PLL_LOCK_SUPERVISOR_TIMEOUT_EN.
module pll_lock_supervisor #(
   parameter int                    N_CH           = 2,
   parameter int                    DIV_W          = 16,
   parameter logic [N_CH*DIV_W-1:0] DIV_LIST       = {16'd7200, 16'd72},
   parameter int                    STABLE_CYCLES  = 1024,
   parameter int                    CNT_W          = 8,
   parameter int                    TIMEOUT_CYCLES = 1000000
) (
   input  logic             clock_in,
   input  logic             resetb,
   input  logic             pll_locked,
   input  logic             clear_count,
   output logic             rst_out_n,
   output logic             ready,
   output logic [N_CH-1:0]  ce,
   output logic [CNT_W-1:0] loss_count,
   output logic             lock_timeout
);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RUN} state_t;
   state_t           r_state;
   logic             r_s1, r_lock_s, r_rst_n, r_ready;
   logic [SW-1:0]    r_stab;
   logic [N_CH-1:0]  r_ce;
   logic [CNT_W-1:0] r_loss;
   logic [DIV_W-1:0] r_div  [N_CH];
   logic [DIV_W-1:0] w_last [N_CH];
   logic             w_run, w_loss_ev;
   assign w_run     = r_state == RUN;
   assign w_loss_ev = w_run && !r_lock_s;
   // a zero divisor behaves like one: terminal count 0, strobe every RUN cycle
   for (genvar g = 0; g < N_CH; g++) begin : g_last
      assign w_last[g] = (DIV_LIST[g*DIV_W +: DIV_W] == '0) ? '0 : DIV_LIST[g*DIV_W +: DIV_W] - DIV_W'(1);
   end
   always_ff @(posedge clock_in or negedge resetb) begin
      if (!resetb) begin
         r_state  <= WAIT_LOCK;
         r_s1     <= 1'b0;
         r_lock_s <= 1'b0;
         r_stab   <= '0;
         r_rst_n  <= 1'b0;
         r_ready  <= 1'b0;
         r_ce     <= '0;
         r_loss   <= '0;
         for (int i = 0; i < N_CH; i++) r_div[i] <= '0;
      end else begin
         r_s1     <= pll_locked;
         r_lock_s <= r_s1;
         r_rst_n  <= w_run;
         r_ready  <= w_run;
         case (r_state)
            WAIT_LOCK: if (r_lock_s) begin
               r_stab  <= '0;
               r_state <= (STABLE_CYCLES <= 1) ? RUN : STABILIZE;
            end
            STABILIZE: if (!r_lock_s) begin
               r_stab  <= '0;
               r_state <= WAIT_LOCK;
            end else begin
               r_stab <= r_stab + SW'(1);
               if (32'(r_stab) + 2 >= STABLE_CYCLES) r_state <= RUN;
            end
            RUN: if (!r_lock_s) r_state <= WAIT_LOCK;
            default: r_state <= WAIT_LOCK;
         endcase
         for (int i = 0; i < N_CH; i++) begin
            r_div[i] <= (w_run && r_div[i] != w_last[i]) ? r_div[i] + DIV_W'(1) : '0;
            r_ce[i]  <= w_run && r_div[i] == w_last[i];
         end
         r_loss <= clear_count ? CNT_W'(w_loss_ev) :
                   (w_loss_ev && r_loss != '1) ? r_loss + CNT_W'(1) : r_loss;
      end
   end
   assign rst_out_n  = r_rst_n;
   assign ready      = r_ready;
   assign ce         = r_ce;
   assign loss_count = r_loss;
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to;
   logic          r_timeout;
   always_ff @(posedge clock_in or negedge resetb) begin
      if (!resetb) begin
         r_to      <= '0;
         r_timeout <= 1'b0;
      end else if (w_run) begin
         r_to      <= '0;
         r_timeout <= 1'b0;
      end else if (r_to != TW'(TIMEOUT_CYCLES)) begin
         r_to <= r_to + TW'(1);
      end else begin
         r_timeout <= 1'b1;
      end
   end
   assign lock_timeout = r_timeout;
`else
   // constant 0; the comparison only keeps the parameter referenced
   assign lock_timeout = TIMEOUT_CYCLES < 0;
`endif
endmodule
